// File: rtl/gyro_link_seq.sv
// gyro_link_seq: run sequencer for the gyro tester DSYNC/DTX/DRX link to the HSI ASIC.
// Resets and arms the link, feeds 32-bit TX words from the FIFO, the pattern generator or
// zeros, counts frames in both directions and drains the RX path before reporting done.
// Build option: define GYRO_SEQ_PATTERN_EN to compile the pattern source; without it,
// cfg_src = 1 acts as the zero source and pat_next is tied low.
`timescale 1ns/1ps

module gyro_link_seq #(
  parameter int unsigned LINK_RST_CYCLES = 16,
  parameter int unsigned ARM_CYCLES      = 64,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  // run control
  input  logic             cfg_start,
  input  logic             cfg_stop,
  input  logic [1:0]       cfg_src,
  input  logic             cfg_rx_bypass,
  input  logic [CNT_W-1:0] cfg_num_frames,
  input  logic [7:0]       cfg_flush_cycles,
  // TX sources
  input  logic [31:0]      tx_fifo_data,
  input  logic             tx_fifo_empty,
  output logic             tx_fifo_rd,
  input  logic [31:0]      pat_data,
  output logic             pat_next,
  // serializer handoff
  output logic [31:0]      ser_word,
  output logic             ser_valid,
  input  logic             ser_ready,
  // deserializer
  input  logic             rx_word_valid,
  // link controls
  output logic             link_rst_n,
  output logic             dsync_en,
  output logic             rx_enable,
  output logic             rx_bypass,
  // status
  output logic             busy,
  output logic             done,
  output logic             rx_timeout,
  output logic             underrun_irq,
  // observability
  output logic [2:0]       state,
  output logic [CNT_W-1:0] frames_sent,
  output logic [CNT_W-1:0] frames_rcvd,
  output logic [CNT_W-1:0] underruns
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLinkRst = 3'd1,
    StArm     = 3'd2,
    StRun     = 3'd3,
    StDrain   = 3'd4,
    StDone    = 3'd5
  } state_e;

  // One shared phase timer covers link reset, arm and drain; 16 bits fits all three.
  localparam int unsigned    TmrW    = 16;
  localparam logic [TmrW-1:0] RstLast = TmrW'(LINK_RST_CYCLES - 1);
  localparam logic [TmrW-1:0] ArmLast = TmrW'(ARM_CYCLES - 1);
  localparam logic [TmrW-1:0] TmrOne  = TmrW'(1);
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q, state_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [1:0]       src_q, src_d;
  logic             bypass_q, bypass_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [CNT_W-1:0] rcvd_q, rcvd_d;
  logic [CNT_W-1:0] under_q, under_d;
  logic             timeout_q, timeout_d;
  logic             irq_q, irq_d;
  logic             link_rst_n_q, dsync_q, busy_q, done_q;

  logic             xfer;
  logic             src_fifo;
  logic             src_pat;
  logic             rx_counting;
  logic [CNT_W-1:0] sent_inc;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + CntOne;
  endfunction

  assign ser_valid   = (state_q == StRun);
  assign xfer        = ser_valid & ser_ready;
  assign src_fifo    = (src_q == 2'd0);
  assign rx_counting = (state_q == StArm) || (state_q == StRun) || (state_q == StDrain);
  assign sent_inc    = sat_inc(sent_q);

`ifdef GYRO_SEQ_PATTERN_EN
  assign src_pat  = (src_q == 2'd1);
  assign pat_next = xfer & src_pat;
`else
  logic unused_pat;
  assign src_pat    = 1'b0;
  assign pat_next   = 1'b0;
  assign unused_pat = ^pat_data;
`endif

  assign tx_fifo_rd = xfer & src_fifo & ~tx_fifo_empty;

  // TX word mux; an empty FIFO sends zeros so the serializer always has a word.
  always_comb begin
    ser_word = 32'h0;
    if (ser_valid) begin
      if (src_fifo) begin
        if (!tx_fifo_empty) begin
          ser_word = tx_fifo_data;
        end
`ifdef GYRO_SEQ_PATTERN_EN
      end else if (src_pat) begin
        ser_word = pat_data;
`endif
      end
    end
  end

  // Next-state, phase timer, counters and sticky flags.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    src_d     = src_q;
    bypass_d  = bypass_q;
    sent_d    = sent_q;
    rcvd_d    = rcvd_q;
    under_d   = under_q;
    timeout_d = timeout_q;
    irq_d     = 1'b0;

    if (xfer) begin
      sent_d = sent_inc;
      if (src_fifo && tx_fifo_empty) begin
        under_d = sat_inc(under_q);
        irq_d   = 1'b1;
      end
    end
    if (rx_word_valid && rx_counting) begin
      rcvd_d = sat_inc(rcvd_q);
    end

    unique case (state_q)
      StIdle, StDone: begin
        // Start beats a simultaneous stop; stop alone does nothing here.
        if (cfg_start) begin
          state_d   = StLinkRst;
          tmr_d     = '0;
          src_d     = cfg_src;
          bypass_d  = cfg_rx_bypass;
          sent_d    = '0;
          rcvd_d    = '0;
          under_d   = '0;
          timeout_d = 1'b0;
        end
      end
      StLinkRst: begin
        if (tmr_q == RstLast) begin
          state_d = StArm;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TmrOne;
        end
      end
      StArm: begin
        if (cfg_stop) begin
          state_d = StDrain;
          tmr_d   = '0;
        end else if (tmr_q == ArmLast) begin
          state_d = StRun;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TmrOne;
        end
      end
      StRun: begin
        if (cfg_stop ||
            (xfer && (cfg_num_frames != '0) && (sent_inc == cfg_num_frames))) begin
          state_d = StDrain;
          tmr_d   = '0;
        end
      end
      StDrain: begin
        if (rcvd_q == sent_q) begin
          state_d = StDone;
        end else if (tmr_q == TmrW'(cfg_flush_cycles)) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end else begin
          tmr_d = tmr_q + TmrOne;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counters and link controls; controls are decoded from the next state so they
  // change on the same edge as the state.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= StIdle;
      tmr_q        <= '0;
      src_q        <= 2'd0;
      bypass_q     <= 1'b0;
      sent_q       <= '0;
      rcvd_q       <= '0;
      under_q      <= '0;
      timeout_q    <= 1'b0;
      irq_q        <= 1'b0;
      link_rst_n_q <= 1'b1;
      dsync_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      src_q        <= src_d;
      bypass_q     <= bypass_d;
      sent_q       <= sent_d;
      rcvd_q       <= rcvd_d;
      under_q      <= under_d;
      timeout_q    <= timeout_d;
      irq_q        <= irq_d;
      link_rst_n_q <= (state_d != StLinkRst);
      dsync_q      <= (state_d == StArm) || (state_d == StRun) || (state_d == StDrain);
      busy_q       <= (state_d == StLinkRst) || (state_d == StArm) ||
                      (state_d == StRun) || (state_d == StDrain);
      done_q       <= (state_d == StDone);
    end
  end

  assign state        = state_q;
  assign link_rst_n   = link_rst_n_q;
  assign dsync_en     = dsync_q;
  assign rx_enable    = dsync_q;
  assign rx_bypass    = bypass_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign rx_timeout   = timeout_q;
  assign underrun_irq = irq_q;
  assign frames_sent  = sent_q;
  assign frames_rcvd  = rcvd_q;
  assign underruns    = under_q;

endmodule

// File: doc/gyro_link_seq.md
# gyro_link_seq

Run sequencer for the gyro tester's DSYNC/DTX/DRX link to the HSI ASIC. It sits between the AXI-lite register block and the link serializer/deserializer. It resets and arms the link, then feeds 32-bit TX words from one of three sources: the TX FIFO, the pattern generator, or zeros. It counts frames sent and received, and drains the receive path before reporting done, so that restart runs (stop, then start again with new data) behave deterministically.

## Interface
- `LINK_RST_CYCLES`, 16: cycles `link_rst_n` is held low at run start.
- `ARM_CYCLES`, 64: cycles between link reset release and the first TX word.
- `CNT_W`, 16: width of the frame counters and `cfg_num_frames`.
- `ACLK` in 1: single clock for all logic.
- `ARESETn` in 1: asynchronous, active-low reset.
- `cfg_start` in 1: one-cycle pulse that begins a run.
- `cfg_stop` in 1: one-cycle pulse that ends a run early.
- `cfg_src` in 2: TX source select; 0 = FIFO, 1 = pattern, 2 or 3 = zero.
- `cfg_rx_bypass` in 1: RX bypass request; latched at start.
- `cfg_num_frames` in CNT_W: frames to send; 0 = continuous.
- `cfg_flush_cycles` in 8: drain timeout in cycles.
- `tx_fifo_data` in 32, `tx_fifo_empty` in 1: first-word-fall-through (FWFT) FIFO head and empty flag.
- `tx_fifo_rd` out 1: FIFO pop.
- `pat_data` in 32, `pat_next` out 1: pattern generator word and advance strobe.
- `ser_word` out 32, `ser_valid` out 1, `ser_ready` in 1: word handoff to the serializer.
- `rx_word_valid` in 1: one pulse per received frame.
- `link_rst_n` out 1, `dsync_en` out 1, `rx_enable` out 1, `rx_bypass` out 1: link controls.
- `busy` out 1, `done` out 1, `rx_timeout` out 1, `underrun_irq` out 1: status.
- `state` out 3, `frames_sent` out CNT_W, `frames_rcvd` out CNT_W, `underruns` out CNT_W: observability.

## Operation
- States and encodings: IDLE = 0, LINK_RST = 1, ARM = 2, RUN = 3, DRAIN = 4, DONE = 5.
- **IDLE or DONE:**
  - `cfg_start` moves to LINK_RST.
  - `cfg_stop` is ignored.
  - If both arrive in the same cycle, start wins.
- **LINK_RST:**
  - On entry: clear all counters and `rx_timeout`; latch `rx_bypass` from `cfg_rx_bypass` and the source from `cfg_src`.
  - `link_rst_n` is low for LINK_RST_CYCLES cycles, then the FSM moves to ARM.
- **ARM:**
  - `dsync_en` = 1 and `rx_enable` = 1.
  - After ARM_CYCLES cycles, move to RUN.
  - `cfg_stop` moves directly to DRAIN.
- **RUN:**
  - `ser_valid` = 1 every cycle; the serializer is never starved.
  - A transfer occurs when `ser_valid` and `ser_ready` are both high.
  - FIFO source: `ser_word` = `tx_fifo_data`; `tx_fifo_rd` = transfer AND NOT `tx_fifo_empty`.
  - FIFO empty at a transfer: send 0x00000000, increment `underruns`, and pulse `underrun_irq` for 1 cycle.
  - Pattern source: `ser_word` = `pat_data`; `pat_next` = transfer.
  - Zero source: `ser_word` = 0.
  - `frames_sent` increments on each transfer.
  - The transfer that makes `frames_sent` == `cfg_num_frames` (when non-zero) moves to DRAIN.
  - `cfg_stop` moves to DRAIN; a transfer in that same cycle is still counted.
- **DRAIN:**
  - `ser_valid` = 0; `dsync_en` and `rx_enable` stay 1.
  - Exit to DONE when `frames_rcvd` == `frames_sent`.
  - If `cfg_flush_cycles` cycles elapse first, set sticky `rx_timeout` and exit to DONE.
  - A value of 0 for `cfg_flush_cycles` exits on the next cycle; set `rx_timeout` only if the counts differ.
- **`frames_rcvd`:** increments on `rx_word_valid` in ARM, RUN and DRAIN only.
- **Counters:** all saturate at 2^CNT_W − 1.
- **Start while busy:** `cfg_start` is ignored in LINK_RST, ARM, RUN and DRAIN.
- **DONE:**
  - `done` = 1 and `busy` = 0.
  - `dsync_en` = 0 and `rx_enable` = 0.
  - Counters hold until the next start.
- **`busy`:** 1 in states 1 through 4.

## Timing
- **Reset values:**
  - `state` = IDLE.
  - `link_rst_n` = 1.
  - All other outputs = 0, including all counters.
- **Mid-run reset:** asserting `ARESETn` mid-run returns the block to reset values immediately (asynchronously).
- **Registered vs combinational outputs:**
  - `state`, `done`, `busy`, the link controls, counters and flags are registered.
  - `ser_word`, `ser_valid`, `tx_fifo_rd` and `pat_next` are combinational from the state, the latched source and the inputs.
- **Start latency:** `cfg_start` sampled at edge N gives `state` = 1 and `link_rst_n` = 0 from edge N+1.
- **Link reset release:** `link_rst_n` returns to 1 at edge N+1+LINK_RST_CYCLES.
- **First word:** `ser_valid` first rises at edge N+1+LINK_RST_CYCLES+ARM_CYCLES.
- **Frame-limit exit:** a final transfer at edge M gives DRAIN from edge M+1.
- **Done:** `done` rises 1 cycle after the drain exit condition is true.
- **Counter updates:** `rx_word_valid` and a transfer in the same cycle both count.

## Configuration
- Macro `GYRO_SEQ_PATTERN_EN`.
- Defined: the pattern source operates as described.
- Undefined:
  - Pattern logic is not compiled.
  - `cfg_src` = 1 behaves as the zero source.
  - `pat_next` is tied to 0 and `pat_data` is unused.

## Test plan
- **Bounded FIFO run:**
  - Stimulus: FIFO source, `cfg_num_frames` = 8, FIFO preloaded with 0x00000001 to 0x00000008, `ser_ready` pulsing every 32 cycles, `rx_word_valid` looped back.
  - Response: words in order; `frames_sent` = `frames_rcvd` = 8; `done` = 1; `rx_timeout` = 0.
- **Underrun:**
  - Stimulus: FIFO source, 3 words loaded, `cfg_num_frames` = 5.
  - Response: words 4 and 5 are 0x00000000; `underruns` = 2; two single-cycle `underrun_irq` pulses.
- **Drain timeout:**
  - Stimulus: zero source, `cfg_num_frames` = 4, `rx_word_valid` never asserted, `cfg_flush_cycles` = 20.
  - Response: DONE reached 21 cycles after DRAIN entry; `rx_timeout` = 1.
- **Stop and restart:**
  - Stimulus: continuous pattern run; `cfg_stop` after 10 transfers; then `cfg_start` from DONE with `cfg_rx_bypass` = 1.
  - Response: `frames_sent` = 10 before the restart; counters clear; `rx_bypass` = 1; `link_rst_n` low for 16 cycles.
- **Mid-run reset:**
  - Stimulus: assert `ARESETn` low in RUN.
  - Response: `state` = 0, `ser_valid` = 0, `link_rst_n` = 1 without waiting for a clock edge; a later start runs normally.
- **Start/stop collision:**
  - Stimulus: `cfg_start` and `cfg_stop` together in IDLE.
  - Response: the FSM enters LINK_RST.
